// File: rtl/bus_reg_responder_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the bus register responder slice:
//   - data / register-index widths and register count
//   - width of the write-commit counter
//   - reset value for the register bank
//   - handshake FSM state encoding (IDLE=00, CAPTURE=01, COMMIT=10)
// ----------------------------------------------------------------------------
package proc_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int CNT_W    = 8;

    localparam logic [7:0] REG_RST_VAL = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        COMMIT  = 2'b10
    } state_e;

endpackage : proc_pkg

// File: rtl/bus_reg_responder_if.sv
// ----------------------------------------------------------------------------
// bus_reg_responder_if
// Groups the datapath write bus, the ALU read ports and the commit status of
// the bus register responder.
//   master : datapath / ALU side (drives bus_data, bus_valid, in_toggle,
//            out_toggle_a/b; observes bus_ready, rd_data_a/b, commit_pulse,
//            last_addr, wr_count)
//   slave  : the responder itself (the reverse directions)
// ----------------------------------------------------------------------------
interface bus_reg_responder_if #(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W,
    parameter int CNT_W  = proc_pkg::CNT_W
);

    // Write bus
    logic [DATA_W-1:0] bus_data;
    logic              bus_valid;
    logic              bus_ready;
    logic [ADDR_W-1:0] in_toggle;

    // Read ports
    logic [ADDR_W-1:0] out_toggle_a;
    logic [ADDR_W-1:0] out_toggle_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;

    // Commit status
    logic              commit_pulse;
    logic [ADDR_W-1:0] last_addr;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output bus_data, bus_valid, in_toggle, out_toggle_a, out_toggle_b,
        input  bus_ready, rd_data_a, rd_data_b, commit_pulse, last_addr, wr_count
    );

    modport slave (
        input  bus_data, bus_valid, in_toggle, out_toggle_a, out_toggle_b,
        output bus_ready, rd_data_a, rd_data_b, commit_pulse, last_addr, wr_count
    );

endinterface : bus_reg_responder_if

// File: rtl/bus_reg_responder_bank.sv
// ----------------------------------------------------------------------------
// reg_bank4
// NUM_REGS x DATA_W register storage with one synchronous write port and two
// combinational read ports. Reads return the stored value only: a read of the
// entry being written shows the old contents until after the write edge.
//   clk, rst          : clock, synchronous active-high reset (clears storage)
//   we, waddr, wdata  : write enable, write index, write data
//   raddr_a, rdata_a  : read port A
//   raddr_b, rdata_b  : read port B
// ----------------------------------------------------------------------------
module reg_bank4 #(
    parameter int DATA_W   = proc_pkg::DATA_W,
    parameter int NUM_REGS = proc_pkg::NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    import proc_pkg::*;

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    // NOTE: every variable written here gets its full default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: the register contents must read 0x00 after reset, so this array is
    // reset like ordinary flops instead of being left as an unreset RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: state updates use <= so every flop samples pre-edge
                // values regardless of statement order.
                mem_q[i] <= DATA_W'(REG_RST_VAL);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule : reg_bank4

// File: rtl/bus_reg_responder.sv
// ----------------------------------------------------------------------------
// bus_reg_responder
// Receiving end of the processor data bus. A byte accepted in IDLE is held for
// one CAPTURE cycle and written into the register bank at the end of COMMIT,
// so writes become visible two edges after acceptance and the bus accepts at
// most one byte every three cycles.
//   clk          : system clock, rising edge
//   rst          : synchronous, active-high reset (aborts any transfer)
//   bus (slave)  : bus_data/bus_valid/bus_ready/in_toggle write handshake,
//                  out_toggle_a/b -> rd_data_a/b read ports,
//                  commit_pulse, last_addr, wr_count commit status
// ----------------------------------------------------------------------------
module bus_reg_responder #(
    parameter int DATA_W   = proc_pkg::DATA_W,
    parameter int NUM_REGS = proc_pkg::NUM_REGS,
    parameter int CNT_W    = proc_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_reg_responder_if.slave   bus
);

    import proc_pkg::*;

    localparam int AW = $clog2(NUM_REGS);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [AW-1:0]     hold_addr_q, hold_addr_d;
    logic              commit_pulse_q, commit_pulse_d;
    logic [AW-1:0]     last_addr_q, last_addr_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    logic              bank_we;
    logic [DATA_W-1:0] rd_a, rd_b;

    // ------------------------------------------------------------------
    // Handshake FSM next-state and status computation
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        hold_data_d    = hold_data_q;
        hold_addr_d    = hold_addr_q;
        commit_pulse_d = 1'b0;
        last_addr_d    = last_addr_q;
        wr_count_d     = wr_count_q;

        unique case (state_q)
            IDLE: begin
                // bus_ready is high in IDLE, so bus_valid alone means a transfer.
                if (bus.bus_valid) begin
                    hold_data_d = bus.bus_data;
                    hold_addr_d = bus.in_toggle;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                // Incoming bus_valid/in_toggle are deliberately ignored here.
                state_d = COMMIT;
            end
            COMMIT: begin
                commit_pulse_d = 1'b1;
                last_addr_d    = hold_addr_q;
                wr_count_d     = wr_count_q + CNT_W'(1);  // wraps silently
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state, hold registers and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            hold_data_q    <= '0;
            hold_addr_q    <= '0;
            commit_pulse_q <= 1'b0;
            last_addr_q    <= '0;
            wr_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            hold_data_q    <= hold_data_d;
            hold_addr_q    <= hold_addr_d;
            commit_pulse_q <= commit_pulse_d;
            last_addr_q    <= last_addr_d;
            wr_count_q     <= wr_count_d;
        end
    end

    // The bank write shares the COMMIT edge with the status update; reset
    // has priority inside the bank, so a COMMIT cut short by rst never lands.
    assign bank_we = (state_q == COMMIT);

    reg_bank4 #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (AW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we),
        .waddr   (hold_addr_q),
        .wdata   (hold_data_q),
        .raddr_a (bus.out_toggle_a),
        .rdata_a (rd_a),
        .raddr_b (bus.out_toggle_b),
        .rdata_b (rd_b)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.bus_ready    = (state_q == IDLE);
    assign bus.rd_data_a    = rd_a;
    assign bus.rd_data_b    = rd_b;
    assign bus.commit_pulse = commit_pulse_q;
    assign bus.last_addr    = last_addr_q;
    assign bus.wr_count     = wr_count_q;

endmodule : bus_reg_responder

// File: tb/tb_bus_reg_responder.sv
// ----------------------------------------------------------------------------
// tb_bus_reg_responder
// Directed bench for bus_reg_responder: a per-cycle vector table (single
// write, back-pressure, all registers with dual read) followed by hand-written
// sequences for reset aborts, reset priority and counter wrap.
// ----------------------------------------------------------------------------
module tb_bus_reg_responder;

    logic clk;
    logic rst;

    int checks;
    int errors;

    bus_reg_responder_if bus_if ();

    bus_reg_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One table row: inputs applied for one cycle and the outputs expected
    // during that cycle (before its closing clock edge).
    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [1:0] in_t;
        logic [1:0] oa;
        logic [1:0] ob;
        logic       e_ready;
        logic       e_pulse;
        logic [7:0] e_rd_a;
        logic [7:0] e_rd_b;
        logic [1:0] e_last;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic [1:0] it,
                       input logic [1:0] oa, input logic [1:0] ob,
                       input logic rdy, input logic pls, input logic [7:0] ra,
                       input logic [7:0] rb, input logic [1:0] last, input logic [7:0] cnt);
        vec_t r;
        r.valid = v;   r.data = d;      r.in_t = it;   r.oa = oa;     r.ob = ob;
        r.e_ready = rdy; r.e_pulse = pls; r.e_rd_a = ra; r.e_rd_b = rb;
        r.e_last = last; r.e_cnt = cnt;
        vecs.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for bus_ready, presents one byte for one cycle, then
    // lets CAPTURE and COMMIT complete. Returns one cycle after the commit edge.
    task automatic write_byte(input logic [1:0] a, input logic [7:0] d);
        int waited = 0;
        while (bus_if.bus_ready !== 1'b1 && waited < 5) begin
            step();
            waited++;
        end
        if (bus_if.bus_ready !== 1'b1) begin
            check("write_ready_timeout", 32'(bus_if.bus_ready), 32'd1);
        end
        bus_if.bus_valid = 1'b1;
        bus_if.bus_data  = d;
        bus_if.in_toggle = a;
        step();
        bus_if.bus_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        bus_if.bus_valid    = 1'b0;
        bus_if.bus_data     = 8'h00;
        bus_if.in_toggle    = 2'd0;
        bus_if.out_toggle_a = 2'd0;
        bus_if.out_toggle_b = 2'd3;

        // ---------------- reset then idle ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst.ready", 32'(bus_if.bus_ready), 32'd1);
        check("rst.rd_a",  32'(bus_if.rd_data_a), 32'h00);
        check("rst.rd_b",  32'(bus_if.rd_data_b), 32'h00);
        check("rst.cnt",   32'(bus_if.wr_count), 32'd0);
        check("rst.pulse", 32'(bus_if.commit_pulse), 32'd0);
        check("rst.last",  32'(bus_if.last_addr), 32'd0);

        // ---------------- vector table ----------------
        //   v   data   it  oa  ob | rdy pls rd_a   rd_b   last cnt
        // single write 0xA5 -> reg2
        add(1, 8'hA5, 2, 2, 0,   1, 0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 0, 2, 0,   0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 0, 2, 0,   0, 0, 8'h00, 8'h00, 0, 0);  // COMMIT: old value
        add(0, 8'h00, 0, 2, 0,   1, 1, 8'hA5, 8'h00, 2, 1);
        add(0, 8'h00, 0, 2, 0,   1, 0, 8'hA5, 8'h00, 2, 1);
        // back-pressure: bus_valid held, data/in_toggle changing every cycle
        add(1, 8'h11, 1, 1, 2,   1, 0, 8'h00, 8'hA5, 2, 1);  // accepted -> reg1
        add(1, 8'h22, 3, 1, 2,   0, 0, 8'h00, 8'hA5, 2, 1);
        add(1, 8'h11, 3, 1, 2,   0, 0, 8'h00, 8'hA5, 2, 1);
        add(1, 8'h22, 1, 1, 2,   1, 1, 8'h11, 8'hA5, 1, 2);  // accepted -> reg1
        add(1, 8'h11, 0, 1, 2,   0, 0, 8'h11, 8'hA5, 1, 2);
        add(1, 8'h22, 0, 1, 2,   0, 0, 8'h11, 8'hA5, 1, 2);
        add(0, 8'h11, 0, 1, 2,   1, 1, 8'h22, 8'hA5, 1, 3);  // last commit wins
        // all registers: 0x01..0x04 -> regs 0..3
        add(1, 8'h01, 0, 0, 3,   1, 0, 8'h00, 8'h00, 1, 3);
        add(0, 8'h00, 0, 0, 3,   0, 0, 8'h00, 8'h00, 1, 3);
        add(0, 8'h00, 0, 0, 3,   0, 0, 8'h00, 8'h00, 1, 3);
        add(1, 8'h02, 1, 0, 3,   1, 1, 8'h01, 8'h00, 0, 4);
        add(0, 8'h00, 0, 0, 3,   0, 0, 8'h01, 8'h00, 0, 4);
        add(0, 8'h00, 0, 0, 3,   0, 0, 8'h01, 8'h00, 0, 4);
        add(1, 8'h03, 2, 0, 3,   1, 1, 8'h01, 8'h00, 1, 5);
        add(0, 8'h00, 0, 0, 3,   0, 0, 8'h01, 8'h00, 1, 5);
        add(0, 8'h00, 0, 0, 3,   0, 0, 8'h01, 8'h00, 1, 5);
        add(1, 8'h04, 3, 0, 3,   1, 1, 8'h01, 8'h00, 2, 6);
        add(0, 8'h00, 0, 0, 3,   0, 0, 8'h01, 8'h00, 2, 6);
        add(0, 8'h00, 0, 0, 3,   0, 0, 8'h01, 8'h00, 2, 6);
        // dual read
        add(0, 8'h00, 0, 0, 3,   1, 1, 8'h01, 8'h04, 3, 7);
        add(0, 8'h00, 0, 1, 1,   1, 0, 8'h02, 8'h02, 3, 7);
        add(0, 8'h00, 0, 2, 3,   1, 0, 8'h03, 8'h04, 3, 7);

        for (int i = 0; i < vecs.size(); i++) begin
            bus_if.bus_valid    = vecs[i].valid;
            bus_if.bus_data     = vecs[i].data;
            bus_if.in_toggle    = vecs[i].in_t;
            bus_if.out_toggle_a = vecs[i].oa;
            bus_if.out_toggle_b = vecs[i].ob;
            #1;
            check($sformatf("v%0d.ready", i), 32'(bus_if.bus_ready),    32'(vecs[i].e_ready));
            check($sformatf("v%0d.pulse", i), 32'(bus_if.commit_pulse), 32'(vecs[i].e_pulse));
            check($sformatf("v%0d.rd_a", i),  32'(bus_if.rd_data_a),    32'(vecs[i].e_rd_a));
            check($sformatf("v%0d.rd_b", i),  32'(bus_if.rd_data_b),    32'(vecs[i].e_rd_b));
            check($sformatf("v%0d.last", i),  32'(bus_if.last_addr),    32'(vecs[i].e_last));
            check($sformatf("v%0d.cnt", i),   32'(bus_if.wr_count),     32'(vecs[i].e_cnt));
            step();
        end
        bus_if.bus_valid = 1'b0;

        // ---------------- reset during CAPTURE ----------------
        bus_if.bus_valid    = 1'b1;
        bus_if.bus_data     = 8'hFF;
        bus_if.in_toggle    = 2'd1;
        bus_if.out_toggle_a = 2'd1;
        step();
        bus_if.bus_valid = 1'b0;
        check("abort_cap.busy", 32'(bus_if.bus_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("abort_cap.ready", 32'(bus_if.bus_ready),    32'd1);
        check("abort_cap.reg1",  32'(bus_if.rd_data_a),    32'h00);
        check("abort_cap.pulse", 32'(bus_if.commit_pulse), 32'd0);
        check("abort_cap.cnt",   32'(bus_if.wr_count),     32'd0);
        step();
        check("abort_cap.pulse2", 32'(bus_if.commit_pulse), 32'd0);
        check("abort_cap.reg1b",  32'(bus_if.rd_data_a),    32'h00);
        check("abort_cap.cnt2",   32'(bus_if.wr_count),     32'd0);

        // ---------------- reset during COMMIT ----------------
        write_byte(2'd2, 8'h5A);
        check("pre_abort.cnt", 32'(bus_if.wr_count), 32'd1);
        bus_if.out_toggle_a = 2'd2;
        bus_if.out_toggle_b = 2'd3;
        bus_if.bus_valid    = 1'b1;
        bus_if.bus_data     = 8'h77;
        bus_if.in_toggle    = 2'd3;
        step();                 // now CAPTURE
        bus_if.bus_valid = 1'b0;
        step();                 // now COMMIT
        check("abort_com.busy", 32'(bus_if.bus_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("abort_com.reg3",  32'(bus_if.rd_data_b),    32'h00);
        check("abort_com.reg2",  32'(bus_if.rd_data_a),    32'h00);
        check("abort_com.pulse", 32'(bus_if.commit_pulse), 32'd0);
        check("abort_com.cnt",   32'(bus_if.wr_count),     32'd0);
        check("abort_com.last",  32'(bus_if.last_addr),    32'd0);
        check("abort_com.ready", 32'(bus_if.bus_ready),    32'd1);

        // ---------------- reset wins over bus_valid ----------------
        bus_if.out_toggle_a = 2'd0;
        bus_if.bus_valid    = 1'b1;
        bus_if.bus_data     = 8'h33;
        bus_if.in_toggle    = 2'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.bus_valid = 1'b0;
        #1;
        check("rst_prio.ready", 32'(bus_if.bus_ready), 32'd1);
        step();
        check("rst_prio.ready2", 32'(bus_if.bus_ready),    32'd1);
        check("rst_prio.pulse",  32'(bus_if.commit_pulse), 32'd0);
        step();
        check("rst_prio.pulse2", 32'(bus_if.commit_pulse), 32'd0);
        check("rst_prio.reg0",   32'(bus_if.rd_data_a),    32'h00);
        check("rst_prio.cnt",    32'(bus_if.wr_count),     32'd0);

        // ---------------- counter wrap ----------------
        bus_if.out_toggle_a = 2'd2;
        for (int k = 0; k < 255; k++) begin
            write_byte(2'(k), 8'(k));
        end
        check("wrap.cnt255",  32'(bus_if.wr_count),  32'hFF);
        check("wrap.last255", 32'(bus_if.last_addr), 32'd2);
        check("wrap.reg2",    32'(bus_if.rd_data_a), 32'hFE);
        write_byte(2'd1, 8'hC3);
        check("wrap.cnt256",   32'(bus_if.wr_count),     32'h00);
        check("wrap.pulse256", 32'(bus_if.commit_pulse), 32'd1);
        write_byte(2'd2, 8'h3C);
        check("wrap.cnt257", 32'(bus_if.wr_count),  32'h01);
        check("wrap.reg2b",  32'(bus_if.rd_data_a), 32'h3C);
        check("wrap.last",   32'(bus_if.last_addr), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bus_reg_responder
